// File: rtl/fire_detector_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fire_detector_pkg
// Brief    : State encodings, default thresholds and hazard helper shared by
//            the fire detector, extinguisher and status display.
// Revision : 1.0
// ============================================================================
package fire_detector_pkg;

    typedef logic [1:0] fd_state_t;
    typedef logic [7:0] temp_t;

    localparam logic [1:0] FD_IDLE     = 2'd0;
    localparam logic [1:0] FD_SUSPECT  = 2'd1;
    localparam logic [1:0] FD_FIRE     = 2'd2;
    localparam logic [1:0] FD_COOLDOWN = 2'd3;

    localparam logic [7:0]  FD_TEMP_THRESH     = 8'd100;
    localparam int unsigned FD_CONFIRM_CYCLES  = 4;
    localparam int unsigned FD_HOLD_CYCLES     = 16;
    localparam int unsigned FD_COOLDOWN_CYCLES = 8;

    function automatic logic fd_hazard(input logic smoke, input temp_t temp,
                                       input temp_t thresh);
        return smoke | (temp >= thresh);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fire_detector_if.sv
`default_nettype none
// ============================================================================
// Module   : fire_detector_if
// Brief    : Sensor inputs and status outputs of the fire detector.
// Revision : 1.0
// ============================================================================
interface fire_detector_if;
    import fire_detector_pkg::*;

    logic      smoke;
    temp_t     temp;
    logic      ack;
    logic      extinguish_en;
    logic      alarm;
    fd_state_t state;
    logic [7:0] fire_events;

    modport master (
        output smoke, temp, ack,
        input  extinguish_en, alarm, state, fire_events
    );

    modport slave (
        input  smoke, temp, ack,
        output extinguish_en, alarm, state, fire_events
    );
endinterface
`default_nettype wire

// File: rtl/dwell_timer.sv
`default_nettype none
// ============================================================================
// Module   : dwell_timer
// Brief    : 8-bit up-counter with clear/increment and a hit flag at limit-1.
// Revision : 1.0
// ============================================================================
module dwell_timer (
    input  wire logic       clk,
    input  wire logic       clr_n,
    input  wire logic       clear_i,
    input  wire logic       inc_i,
    input  wire logic [7:0] limit_i,
    output logic            hit_o
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign hit_o = (count_q == (limit_i - 8'd1));

endmodule
`default_nettype wire

// File: rtl/fire_detector.sv
`default_nettype none
// ============================================================================
// Module   : fire_detector
// Brief    : Confirms smoke/over-temperature hazards and sequences the
//            extinguisher enable, alarm and fire-event count.
// Revision : 1.0
// ============================================================================
module fire_detector
    import fire_detector_pkg::*;
#(
    parameter logic [7:0]  TEMP_THRESH     = FD_TEMP_THRESH,
    parameter int unsigned CONFIRM_CYCLES  = FD_CONFIRM_CYCLES,
    parameter int unsigned HOLD_CYCLES     = FD_HOLD_CYCLES,
    parameter int unsigned COOLDOWN_CYCLES = FD_COOLDOWN_CYCLES
) (
    input  wire logic      clk,
    input  wire logic      clr_n,
    fire_detector_if.slave bus
);

    localparam logic [7:0] C_CONFIRM_LIMIT  = CONFIRM_CYCLES[7:0];
    localparam logic [7:0] C_HOLD_LIMIT     = HOLD_CYCLES[7:0];
    localparam logic [7:0] C_COOLDOWN_LIMIT = COOLDOWN_CYCLES[7:0];

    fd_state_t  state_q;
    fd_state_t  state_d;
    logic [7:0] events_q;
    logic [7:0] events_d;

    logic       w_hazard;
    logic       w_tmr_clr;
    logic       w_tmr_inc;
    logic       w_tmr_hit;
    logic [7:0] w_limit;
    logic       w_fire_entry;

    assign w_hazard = fd_hazard(bus.smoke, bus.temp, TEMP_THRESH);

    // Limit select kept apart from the FSM so hit never feeds back into it.
    always_comb begin
        w_limit = C_CONFIRM_LIMIT;
        case (state_q)
            FD_FIRE:     w_limit = C_HOLD_LIMIT;
            FD_COOLDOWN: w_limit = C_COOLDOWN_LIMIT;
            default:     w_limit = C_CONFIRM_LIMIT;
        endcase
    end

    dwell_timer u_dwell_timer (
        .clk     (clk),
        .clr_n   (clr_n),
        .clear_i (w_tmr_clr),
        .inc_i   (w_tmr_inc),
        .limit_i (w_limit),
        .hit_o   (w_tmr_hit)
    );

    always_comb begin
        state_d      = state_q;
        w_tmr_clr    = 1'b0;
        w_tmr_inc    = 1'b0;
        w_fire_entry = 1'b0;
        case (state_q)
            FD_IDLE: begin
                // The first hazard cycle already counts toward confirmation.
                if (w_hazard) begin
                    state_d   = FD_SUSPECT;
                    w_tmr_inc = 1'b1;
                end
            end
            FD_SUSPECT: begin
                if (!w_hazard) begin
                    state_d   = FD_IDLE;
                    w_tmr_clr = 1'b1;
                end else if (w_tmr_hit) begin
                    state_d      = FD_FIRE;
                    w_tmr_clr    = 1'b1;
                    w_fire_entry = 1'b1;
                end else begin
                    w_tmr_inc = 1'b1;
                end
            end
            FD_FIRE: begin
                if (w_tmr_hit) begin
                    w_tmr_clr = 1'b1;
                    if (!w_hazard) begin
                        state_d = FD_COOLDOWN;
                    end
                end else begin
                    w_tmr_inc = 1'b1;
                end
            end
            FD_COOLDOWN: begin
                if (w_hazard) begin
                    state_d      = FD_FIRE;
                    w_tmr_clr    = 1'b1;
                    w_fire_entry = 1'b1;
                end else if (bus.ack || w_tmr_hit) begin
                    state_d   = FD_IDLE;
                    w_tmr_clr = 1'b1;
                end else begin
                    w_tmr_inc = 1'b1;
                end
            end
            default: begin
                state_d   = FD_IDLE;
                w_tmr_clr = 1'b1;
            end
        endcase
    end

    always_comb begin
        events_d = events_q;
        if (w_fire_entry && (events_q != 8'hFF)) begin
            events_d = events_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q  <= FD_IDLE;
            events_q <= '0;
        end else begin
            state_q  <= state_d;
            events_q <= events_d;
        end
    end

    assign bus.extinguish_en = (state_q == FD_FIRE);
    assign bus.alarm         = (state_q == FD_FIRE) || (state_q == FD_COOLDOWN);
    assign bus.state         = state_q;
    assign bus.fire_events   = events_q;

endmodule
`default_nettype wire

// File: tb/tb_fire_detector.sv
`default_nettype none
// ============================================================================
// Module   : tb_fire_detector
// Brief    : Table vectors, corner sequences and random traffic for fire_detector.
// Revision : 1.0
// ============================================================================
module tb_fire_detector;

    localparam int THRESH   = 100;
    localparam int CONFIRM  = 4;
    localparam int HOLD     = 16;
    localparam int COOLDOWN = 8;

    localparam int P_IDLE = 0, P_SUSPECT = 1, P_FIRE = 2, P_COOL = 3;

    logic clk;
    logic clr_n;
    fire_detector_if bus ();

    fire_detector #(
        .TEMP_THRESH     (8'd100),
        .CONFIRM_CYCLES  (CONFIRM),
        .HOLD_CYCLES     (HOLD),
        .COOLDOWN_CYCLES (COOLDOWN)
    ) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit       rn;
        bit       sm;
        int       tp;
        bit       ak;
        int       st;
        int       en;
        int       al;
        int       ev;
    } vec_t;

    vec_t tbl[$];
    int checks = 0;
    int errors = 0;

    // Reference: phase, cycles spent in the current phase, events seen.
    int m_phase = P_IDLE;
    int m_age   = 0;
    int m_ev    = 0;

    task automatic model_step(input bit rn, input bit sm, input int tp, input bit ak);
        bit hz;
        hz = sm || (tp >= THRESH);
        if (!rn) begin
            m_phase = P_IDLE; m_age = 0; m_ev = 0;
            return;
        end
        case (m_phase)
            P_IDLE:    if (hz) begin m_phase = P_SUSPECT; m_age = 1; end
            P_SUSPECT: begin
                if (!hz) begin m_phase = P_IDLE; m_age = 0; end
                else if (m_age + 1 >= CONFIRM) begin
                    m_phase = P_FIRE; m_age = 0;
                    if (m_ev < 255) m_ev = m_ev + 1;
                end else m_age = m_age + 1;
            end
            P_FIRE: begin
                if (m_age + 1 < HOLD) m_age = m_age + 1;
                else begin
                    m_age = 0;
                    if (!hz) m_phase = P_COOL;
                end
            end
            default: begin
                if (hz) begin
                    m_phase = P_FIRE; m_age = 0;
                    if (m_ev < 255) m_ev = m_ev + 1;
                end else if (ak || (m_age + 1 >= COOLDOWN)) begin
                    m_phase = P_IDLE; m_age = 0;
                end else m_age = m_age + 1;
            end
        endcase
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step(input bit rn, input bit sm, input int tp, input bit ak);
        clr_n     = rn;
        bus.smoke = sm;
        bus.temp  = 8'(tp);
        bus.ack   = ak;
        @(posedge clk);
        model_step(rn, sm, tp, ak);
        #1;
    endtask

    task automatic chk_model();
        chk("state", int'(bus.state), m_phase);
        chk("extinguish_en", int'(bus.extinguish_en), int'(m_phase == P_FIRE));
        chk("alarm", int'(bus.alarm), int'(m_phase == P_FIRE || m_phase == P_COOL));
        chk("fire_events", int'(bus.fire_events), m_ev);
    endtask

    task automatic cyc(input bit rn, input bit sm, input int tp, input bit ak);
        step(rn, sm, tp, ak);
        chk_model();
    endtask

    function automatic vec_t mk(input bit rn, input bit sm, input int tp, input bit ak,
                                input int st, input int en, input int al, input int ev);
        vec_t v;
        v.rn = rn; v.sm = sm; v.tp = tp; v.ak = ak;
        v.st = st; v.en = en; v.al = al; v.ev = ev;
        return v;
    endfunction

    initial begin
        int ev0;
        bit burst;
        clr_n = 1'b0; bus.smoke = 1'b0; bus.temp = 8'd0; bus.ack = 1'b0;

        // Reset held with hazard present, then exact-threshold confirmation.
        for (int i = 0; i < 2; i++)  tbl.push_back(mk(0, 1, 200, 0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++)  tbl.push_back(mk(1, 0, 100, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 100, 0, 2, 1, 1, 1));
        for (int i = 0; i < 15; i++) tbl.push_back(mk(1, 0, 99, 0, 2, 1, 1, 1));
        for (int i = 0; i < 8; i++)  tbl.push_back(mk(1, 0, 99, 0, 3, 0, 1, 1));
        tbl.push_back(mk(1, 0, 99, 0, 0, 0, 0, 1));
        // Aborted confirmation.
        for (int i = 0; i < 3; i++)  tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1));
        for (int i = 0; i < 3; i++)  tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rn, tbl[i].sm, tbl[i].tp, tbl[i].ak);
            chk($sformatf("vec%0d.state", i), int'(bus.state), tbl[i].st);
            chk($sformatf("vec%0d.en", i), int'(bus.extinguish_en), tbl[i].en);
            chk($sformatf("vec%0d.alarm", i), int'(bus.alarm), tbl[i].al);
            chk($sformatf("vec%0d.events", i), int'(bus.fire_events), tbl[i].ev);
        end

        // Confirm, ack during FIRE is ignored, cooldown, re-ignite on cooldown cycle 3.
        ev0 = int'(bus.fire_events);
        for (int i = 0; i < CONFIRM; i++) cyc(1, 1, 0, 0);
        chk("confirm.state", int'(bus.state), 2);
        chk("confirm.events", int'(bus.fire_events), ev0 + 1);
        for (int i = 0; i < HOLD - 1; i++) begin
            cyc(1, 0, 0, 1);
            chk("ack_in_fire.en", int'(bus.extinguish_en), 1);
        end
        cyc(1, 0, 0, 0);
        chk("window_end.state", int'(bus.state), 3);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        chk("reignite.state", int'(bus.state), 2);
        chk("reignite.events", int'(bus.fire_events), ev0 + 2);

        // Hazard at window end restarts the window without counting an event.
        for (int i = 0; i < HOLD; i++) cyc(1, 1, 0, 0);
        chk("rewindow.state", int'(bus.state), 2);
        chk("rewindow.events", int'(bus.fire_events), ev0 + 2);

        // Ack in cooldown with no hazard.
        for (int i = 0; i < HOLD; i++) cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 1);
        chk("ack_cool.state", int'(bus.state), 0);
        chk("ack_cool.alarm", int'(bus.alarm), 0);

        // Ack and smoke together in cooldown: hazard wins.
        for (int i = 0; i < CONFIRM; i++) cyc(1, 1, 0, 0);
        for (int i = 0; i < HOLD; i++) cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 1);
        chk("ack_smoke.state", int'(bus.state), 2);

        // Saturation through repeated re-ignition.
        for (int n = 0; n < 260; n++) begin
            for (int i = 0; i < HOLD; i++) cyc(1, 0, 0, 0);
            cyc(1, 1, 0, 0);
        end
        chk("saturate.events", int'(bus.fire_events), 255);

        // Reset at hold cycle 7.
        for (int i = 0; i < 7; i++) cyc(1, 0, 0, 0);
        chk("pre_reset.en", int'(bus.extinguish_en), 1);
        cyc(0, 1, 0, 0);
        chk("mid_reset.en", int'(bus.extinguish_en), 0);
        chk("mid_reset.state", int'(bus.state), 0);
        chk("mid_reset.events", int'(bus.fire_events), 0);

        // Bursty random traffic against the reference.
        burst = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            bit rn, sm, ak;
            int tp;
            if ($urandom_range(0, 7) == 0) burst = ~burst;
            rn = ($urandom_range(0, 399) != 0);
            ak = ($urandom_range(0, 7) == 0);
            if (burst) begin
                sm = ($urandom_range(0, 15) != 0);
                tp = $urandom_range(0, 255);
            end else begin
                sm = 1'b0;
                tp = $urandom_range(0, 104);
            end
            cyc(rn, sm, tp, ak);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
